// File: rtl/apb_arbiter.sv
// Two-master round-robin arbiter driving a single APB requester port.
// m0 is the instruction-fetch master, m1 the data master; a watchdog aborts stuck transfers.
module apb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_write,
    input  logic [3:0]            m0_stb,
    output logic                  m0_done,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_write,
    input  logic [3:0]            m1_stb,
    output logic                  m1_done,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,

    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr
);

    // The watchdog only ever holds 0..TIMEOUT-1; hitting the last value with pready low aborts.
    localparam int WD_WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t              state;
    logic                grant;
    logic                last_grant;
    logic [WD_WIDTH-1:0] watchdog;
    logic                pick_m1;

    // m1 wins when it is the only requester, or on a tie when m0 was served last.
    assign pick_m1 = m1_req & (~m0_req | ~last_grant);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            watchdog   <= '0;
            paddr      <= '0;
            pdata      <= '0;
            pwrite     <= 1'b0;
            pstb       <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            m0_done    <= 1'b0;
            m0_rdata   <= '0;
            m0_err     <= 1'b0;
            m1_done    <= 1'b0;
            m1_rdata   <= '0;
            m1_err     <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req | m1_req) begin
                        grant  <= pick_m1;
                        paddr  <= pick_m1 ? m1_addr  : m0_addr;
                        pdata  <= pick_m1 ? m1_wdata : m0_wdata;
                        pwrite <= pick_m1 ? m1_write : m0_write;
                        pstb   <= pick_m1 ? m1_stb   : m0_stb;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    watchdog <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // A completing pready takes priority over a watchdog expiring in the same cycle.
                    if (pready) begin
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        last_grant <= grant;
                        state      <= IDLE;
                        if (grant) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= prdata;
                            m1_err   <= perr;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= prdata;
                            m0_err   <= perr;
                        end
                    end else if (watchdog == WD_LAST) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= IDLE;
                        if (grant) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= '0;
                            m1_err   <= 1'b1;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= '0;
                            m0_err   <= 1'b1;
                        end
                    end else begin
                        watchdog <= watchdog + WD_WIDTH'(1);
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed table, hand-written corner sequences
// and randomized transfers checked against a transaction-level model.
module tb_apb_arbiter;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        m0_req, m0_write, m0_done, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_stb;
    logic        m1_req, m1_write, m1_done, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_stb;
    logic [31:0] paddr, pdata, prdata;
    logic        pwrite, psel, penable, pready, perr;
    logic [3:0]  pstb;

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] addr0, wdata0;
        logic        write0;
        logic [3:0]  stb0;
        logic [31:0] addr1, wdata1;
        logic        write1;
        logic [3:0]  stb1;
        int          waits;
        logic        perr_v;
        logic [31:0] prdata_v;
        int          exp_grant;
        int          exp_access;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_last;
    logic [31:0] hold_rdata [2];
    logic        hold_err   [2];
    vec_t        tbl [5];

    apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
        .m0_stb(m0_stb), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
        .m1_stb(m1_stb), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .perr(perr)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] mask,
                                input logic [31:0] a0, input logic [31:0] d0, input logic w0, input logic [3:0] s0,
                                input logic [31:0] a1, input logic [31:0] d1, input logic w1, input logic [3:0] s1,
                                input int waits, input logic pe, input logic [31:0] prd,
                                input int g, input int acc, input logic err, input logic [31:0] rd);
        vec_t v;
        v.mask = mask;
        v.addr0 = a0; v.wdata0 = d0; v.write0 = w0; v.stb0 = s0;
        v.addr1 = a1; v.wdata1 = d1; v.write1 = w1; v.stb1 = s1;
        v.waits = waits; v.perr_v = pe; v.prdata_v = prd;
        v.exp_grant = g; v.exp_access = acc; v.exp_err = err; v.exp_rdata = rd;
        return v;
    endfunction

    // Transaction-level model: round-robin on ties, abort once the slave waits TO or more cycles.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        if (v.mask == 2'b11) r.exp_grant = (model_last == 1) ? 0 : 1;
        else                 r.exp_grant = v.mask[1] ? 1 : 0;
        if (v.waits < TO) begin
            r.exp_access = v.waits + 1;
            r.exp_err    = v.perr_v;
            r.exp_rdata  = v.prdata_v;
        end else begin
            r.exp_access = TO;
            r.exp_err    = 1'b1;
            r.exp_rdata  = 32'h0;
        end
        return r;
    endfunction

    task automatic modelReset();
        model_last    = 1;
        hold_rdata[0] = '0; hold_rdata[1] = '0;
        hold_err[0]   = 1'b0; hold_err[1] = 1'b0;
    endtask

    task automatic doReset();
        presetn = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; pready = 1'b0; perr = 1'b0; prdata = '0;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        modelReset();
    endtask

    // Drives one transfer from IDLE to its done pulse, acting as the APB slave.
    task automatic applyStimulus(input vec_t v, input bit keep);
        int c = 0, first_setup = -1, setup_n = 0, acc = 0, unstable = 0, got = -1, other;
        bit done_seen = 0, both = 0;
        logic psel_done = 1'b1;
        logic [31:0] cap_addr = '0, cap_data = '0, g_rdata = '0, o_rdata = '0;
        logic cap_write = 1'b0, g_err = 1'b0, o_err = 1'b0;
        logic [3:0] cap_stb = '0;
        m0_addr = v.addr0; m0_wdata = v.wdata0; m0_write = v.write0; m0_stb = v.stb0;
        m1_addr = v.addr1; m1_wdata = v.wdata1; m1_write = v.write1; m1_stb = v.stb1;
        m0_req = v.mask[0]; m1_req = v.mask[1];
        pready = 1'b0;
        other = 1 - v.exp_grant;
        while (!done_seen && c < 40) begin
            @(posedge pclk); @(negedge pclk); c++;
            if (m0_done || m1_done) begin
                done_seen = 1; both = m0_done && m1_done; got = m1_done ? 1 : 0;
                psel_done = psel;
                g_rdata = v.exp_grant ? m1_rdata : m0_rdata; g_err = v.exp_grant ? m1_err : m0_err;
                o_rdata = v.exp_grant ? m0_rdata : m1_rdata; o_err = v.exp_grant ? m0_err : m1_err;
                pready = 1'b0;
            end else if (psel && !penable) begin
                setup_n++;
                if (first_setup < 0) first_setup = c;
                cap_addr = paddr; cap_data = pdata; cap_write = pwrite; cap_stb = pstb;
                pready = 1'b0; prdata = $urandom;
            end else if (psel && penable) begin
                acc++;
                if (paddr !== cap_addr || pdata !== cap_data || pwrite !== cap_write || pstb !== cap_stb)
                    unstable++;
                pready = (acc > v.waits);
                if (pready) begin perr = v.perr_v; prdata = v.prdata_v; end
                else begin perr = 1'($urandom_range(0, 1)); prdata = $urandom; end
            end else begin
                pready = 1'b0; perr = 1'b0; prdata = $urandom;
            end
        end
        checkOutput("done_seen", 32'(done_seen), 32'd1);
        checkOutput("grant", 32'(got), 32'(v.exp_grant));
        checkOutput("single_done", 32'(both), 32'd0);
        checkOutput("setup_latency", 32'(first_setup), 32'd1);
        checkOutput("setup_len", 32'(setup_n), 32'd1);
        checkOutput("access_len", 32'(acc), 32'(v.exp_access));
        checkOutput("fields_stable", 32'(unstable), 32'd0);
        checkOutput("paddr", cap_addr, v.exp_grant ? v.addr1 : v.addr0);
        checkOutput("pdata", cap_data, v.exp_grant ? v.wdata1 : v.wdata0);
        checkOutput("pwrite", 32'(cap_write), 32'(v.exp_grant ? v.write1 : v.write0));
        checkOutput("pstb", 32'(cap_stb), 32'(v.exp_grant ? v.stb1 : v.stb0));
        checkOutput("psel_in_done", 32'(psel_done), 32'd0);
        checkOutput("rdata", g_rdata, v.exp_rdata);
        checkOutput("err", 32'(g_err), 32'(v.exp_err));
        checkOutput("other_rdata_hold", o_rdata, hold_rdata[other]);
        checkOutput("other_err_hold", 32'(o_err), 32'(hold_err[other]));
        hold_rdata[v.exp_grant] = v.exp_rdata;
        hold_err[v.exp_grant]   = v.exp_err;
        if (v.waits < TO) model_last = v.exp_grant;
        if (!keep) begin
            if (v.exp_grant == 1) m1_req = 1'b0;
            else                  m0_req = 1'b0;
        end
    endtask

    initial begin
        int k;
        vec_t v;
        presetn = 1'b1;
        m0_req = 0; m0_addr = '0; m0_wdata = '0; m0_write = 0; m0_stb = '0;
        m1_req = 0; m1_addr = '0; m1_wdata = '0; m1_write = 0; m1_stb = '0;
        pready = 0; perr = 0; prdata = '0;
        #2 presetn = 1'b0;
        repeat (2) @(negedge pclk);
        checkOutput("rst_psel", 32'(psel), 32'd0);
        checkOutput("rst_penable", 32'(penable), 32'd0);
        checkOutput("rst_paddr", paddr, 32'd0);
        checkOutput("rst_pdata", pdata, 32'd0);
        checkOutput("rst_pwrite", 32'(pwrite), 32'd0);
        checkOutput("rst_pstb", 32'(pstb), 32'd0);
        checkOutput("rst_done", 32'({m0_done, m1_done}), 32'd0);
        checkOutput("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        checkOutput("rst_err", 32'({m0_err, m1_err}), 32'd0);
        presetn = 1'b1;
        modelReset();

        tbl[0] = mk(2'b01, 32'h8000_0010, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 4'h0,
                    0, 1'b0, 32'hDEAD_BEEF, 0, 1, 1'b0, 32'hDEAD_BEEF);
        tbl[1] = mk(2'b10, 32'h0, 32'h0, 1'b0, 4'h0, 32'h1000_0000, 32'h41, 1'b1, 4'h1,
                    3, 1'b0, 32'h0, 1, 4, 1'b0, 32'h0);
        tbl[2] = mk(2'b01, 32'h3000_0000, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 4'h0,
                    1, 1'b1, 32'h1234_5678, 0, 2, 1'b1, 32'h1234_5678);
        tbl[3] = mk(2'b11, 32'h2000_0004, 32'hA5A5_A5A5, 1'b1, 4'h3, 32'h4000_0008, 32'h1111_1111, 1'b0, 4'hF,
                    0, 1'b0, 32'hCAFE_F00D, 1, 1, 1'b0, 32'hCAFE_F00D);
        tbl[4] = mk(2'b01, 32'h2000_0004, 32'hA5A5_A5A5, 1'b1, 4'h3, 32'h0, 32'h0, 1'b0, 4'h0,
                    2, 1'b0, 32'h0BAD_F00D, 0, 3, 1'b0, 32'h0BAD_F00D);
        for (int i = 0; i < 5; i++) applyStimulus(tbl[i], 1'b0);

        // Both masters held continuously after reset alternate m0, m1, m0, m1.
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(mk(2'b11, 32'h0000_1000, 32'h0, 1'b0, 4'hF, 32'h0000_2000, 32'h9, 1'b1, 4'hF,
                             0, 1'b0, 32'h100 + 32'(i), i % 2, 1, 1'b0, 32'h100 + 32'(i)), 1'b1);
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge pclk); @(negedge pclk);
        checkOutput("idle_after_rr", 32'(psel), 32'd0);

        // Stuck slave: watchdog aborts after TO access cycles.
        applyStimulus(mk(2'b10, 32'h0, 32'h0, 1'b0, 4'h0, 32'h5000_0000, 32'h0, 1'b0, 4'hF,
                         10, 1'b0, 32'hFFFF_FFFF, 1, TO, 1'b1, 32'h0), 1'b0);
        @(posedge pclk); @(negedge pclk);
        checkOutput("idle_after_abort", 32'(psel), 32'd0);

        // Reset mid-ACCESS with m1 pending.
        m0_addr = 32'h7000_0000; m0_write = 1'b0; m0_stb = 4'hF; m0_req = 1'b1; pready = 1'b0;
        k = 0;
        do begin
            @(posedge pclk); @(negedge pclk); k++;
        end while (!(psel && penable) && k < 10);
        checkOutput("reach_access", 32'(psel && penable), 32'd1);
        m1_addr = 32'h6000_0000; m1_wdata = 32'h77; m1_write = 1'b1; m1_stb = 4'hC; m1_req = 1'b1;
        @(posedge pclk); @(negedge pclk);
        presetn = 1'b0; m0_req = 1'b0;
        #1;
        checkOutput("async_psel", 32'(psel), 32'd0);
        checkOutput("async_penable", 32'(penable), 32'd0);
        @(posedge pclk); @(negedge pclk);
        checkOutput("no_done_on_reset", 32'({m0_done, m1_done}), 32'd0);
        presetn = 1'b1;
        modelReset();
        applyStimulus(mk(2'b10, 32'h0, 32'h0, 1'b0, 4'h0, 32'h6000_0000, 32'h77, 1'b1, 4'hC,
                         1, 1'b0, 32'h55, 1, 2, 1'b0, 32'h55), 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                m0_req = 1'b0; m1_req = 1'b0;
                @(posedge pclk); @(negedge pclk);
                checkOutput("rand_idle", 32'(psel), 32'd0);
            end
            v = mk(2'($urandom_range(1, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom, 0, 0, 1'b0, 32'h0);
            applyStimulus(predict(v), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of ACCESS cycles before an abort.
REQ-004 pclk  input  1  bus clock; all state changes on its rising edge.
REQ-005 presetn  input  1  reset; asynchronous, active-low.
REQ-006 mN_req  input  1  request, for N=0 (instruction fetch) and N=1 (data); held with its payload until mN_done.
REQ-007 mN_addr  input  ADDR_WIDTH  request address, N=0,1.
REQ-008 mN_wdata  input  DATA_WIDTH  write data, N=0,1.
REQ-009 mN_write  input  1  1=write, 0=read, N=0,1.
REQ-010 mN_stb  input  4  byte strobes, N=0,1.
REQ-011 mN_done  output  1  one-cycle completion pulse, N=0,1.
REQ-012 mN_rdata  output  DATA_WIDTH  read data, valid while mN_done is high, N=0,1.
REQ-013 mN_err  output  1  error flag, valid while mN_done is high, N=0,1.
REQ-014 paddr/pdata/pwrite/pstb  output  ADDR_WIDTH/DATA_WIDTH/1/4  APB request fields to the address decoder.
REQ-015 psel, penable  output  1 each  APB phase controls.
REQ-016 prdata  input  DATA_WIDTH  APB read data.
REQ-017 pready, perr  input  1 each  APB completion and error.

Function
REQ-018 SHALL implement the states IDLE, SETUP and ACCESS.
REQ-019 IDLE: psel=0, penable=0; if any mN_req=1 at the clock edge, latch the winner's addr/wdata/write/stb into APB output registers and go to SETUP.
REQ-020 Arbitration SHALL be round-robin: when both request, grant the requester not granted last; a single requester is always granted.
REQ-021 SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-022 ACCESS: psel=1, penable=1; stay in ACCESS while pready=0.
REQ-023 In ACCESS with pready=1 at the edge: capture prdata into the granted mN_rdata and perr into mN_err, pulse mN_done for the next cycle, update last-grant, and go to IDLE.
REQ-024 paddr/pdata/pwrite/pstb SHALL stay constant from SETUP through the completing ACCESS cycle; requester inputs are not re-sampled.
REQ-025 A watchdog counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0.
REQ-026 When the watchdog reaches TIMEOUT with pready=0, the block SHALL abort: mN_done=1 and mN_err=1 next cycle, mN_rdata=0, go to IDLE.
REQ-027 If pready=1 and the timeout occur in the same cycle, pready SHALL win and complete normally.
REQ-028 The ungranted requester's mN_done SHALL stay 0, and its mN_rdata/mN_err SHALL hold their previous values.
REQ-029 A requester SHALL drop mN_req in the cycle mN_done is high unless it is issuing a new transfer; a held request is treated as new in IDLE.
REQ-030 Minimum transaction latency is 4 cycles (IDLE sample, SETUP, ACCESS with pready=1, done); back-to-back grants SHALL have one IDLE cycle between them.
REQ-031 Outputs other than mN_done/mN_rdata/mN_err SHALL be registered and glitch-free.

Reset
REQ-032 While presetn=0, the block SHALL be in IDLE with psel=0, penable=0, paddr=0, pdata=0, pwrite=0, pstb=0, mN_done=0, mN_rdata=0, mN_err=0, watchdog=0, and last-grant=1 (so m0 wins the first tie).
REQ-033 When presetn is asserted mid-transaction, the block SHALL drop psel/penable immediately (asynchronously), produce no mN_done for the aborted transfer, and resume normal operation on the first edge after presetn=1.

Verification
REQ-034 m0 read of 0x80000010, pready=1 in the first ACCESS cycle, prdata=0xDEADBEEF -> psel high for 2 cycles; m0_done pulse 1 cycle with m0_rdata=0xDEADBEEF and m0_err=0; m1_done=0.
REQ-035 m0 and m1 request together after reset, both held -> grant order m0, m1, m0, m1; each transaction is separated by exactly one IDLE cycle.
REQ-036 m1 write to 0x10000000, pdata=0x41, pstb=0x1, pready held low 3 cycles -> ACCESS lasts 4 cycles; paddr/pdata/pstb stay stable throughout; m1_done with m1_err=0.
REQ-037 Access to 0x30000000 with perr=1 and pready=1 -> granted mN_done with mN_err=1.
REQ-038 pready stuck at 0 with TIMEOUT=4 -> abort after 4 ACCESS cycles with mN_err=1, mN_rdata=0, state IDLE.
REQ-039 presetn pulsed low during ACCESS -> psel=0 and penable=0 immediately; no done pulse; after release, a pending m1 request is serviced normally.
